// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_receiver: line input, control inputs
// and the registered byte/flag outputs.
interface uart_rx_if;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  modport slave (
    input  baud_select, Rx_EN, RxD,
    output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
  );

  modport master (
    output baud_select, Rx_EN, RxD,
    input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
  );
endinterface

// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling, 100 MHz clock.
// Outputs are registered and pulse for one cycle after the stop-bit sample.
module uart_receiver (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [2:0]  baud_q, baud_d;
  logic [14:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  smp_cnt_q, smp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;

  logic        start_edge, tick, half_bit, centre;
  logic        par_bad, stop_bad;

  // Clocks per 16x tick at 100 MHz.
  function automatic logic [14:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'b000:  baud_div = 15'd20833;
      3'b001:  baud_div = 15'd5208;
      3'b010:  baud_div = 15'd1302;
      3'b011:  baud_div = 15'd651;
      3'b100:  baud_div = 15'd326;
      3'b101:  baud_div = 15'd163;
      3'b110:  baud_div = 15'd109;
      default: baud_div = 15'd54;
    endcase
  endfunction

  assign start_edge = rx.Rx_EN && rxd_prev_q && !rxd_s2_q;
  assign tick       = (tick_cnt_q == (baud_div(baud_q) - 15'd1));
  assign half_bit   = tick && (smp_cnt_q == 4'd7);
  assign centre     = tick && (smp_cnt_q == 4'd15);
  assign par_bad    = ^{shift_q, par_q};
  assign stop_bad   = !rxd_s2_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rx.Rx_EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_edge) state_d = START;
        START:   if (half_bit) state_d = rxd_s2_q ? IDLE : DATA;
        DATA:    if (centre && (bit_cnt_q == 3'd7)) state_d = PARITY;
        PARITY:  if (centre) state_d = STOP;
        STOP:    if (centre) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    baud_d     = baud_q;
    tick_cnt_d = tick ? 15'd0 : tick_cnt_q + 15'd1;
    smp_cnt_d  = tick ? smp_cnt_q + 4'd1 : smp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tick_cnt_d = 15'd0;
        smp_cnt_d  = 4'd0;
        bit_cnt_d  = 3'd0;
        if (start_edge) baud_d = rx.baud_select;
      end
      // Restart the 16-tick count at mid start bit so later samples land on bit centres.
      START:  if (half_bit) smp_cnt_d = 4'd0;
      DATA: begin
        if (centre) begin
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: if (centre) par_d = rxd_s2_q;
      STOP: begin
        if (centre) begin
          perr_d = par_bad;
          ferr_d = stop_bad;
          if (!par_bad && !stop_bad) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (!rx.Rx_EN) begin
      tick_cnt_d = 15'd0;
      smp_cnt_d  = 4'd0;
      bit_cnt_d  = 3'd0;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      baud_q     <= 3'd0;
      tick_cnt_q <= 15'd0;
      smp_cnt_q  <= 4'd0;
      bit_cnt_q  <= 3'd0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_s1_q   <= rx.RxD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      baud_q     <= baud_d;
      tick_cnt_q <= tick_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign rx.Rx_DATA   = data_q;
  assign rx.Rx_VALID  = valid_q;
  assign rx.Rx_PERROR = perr_q;
  assign rx.Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames at 115200 baud against a frame-level model of
// the expected byte/flag outcome for each frame.
module tb_uart_receiver;

  localparam int CPB = 864;

  logic clk = 1'b0;
  logic reset;
  uart_rx_if rx ();

  uart_receiver dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_perr  = 0;
  int n_ferr  = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_data;

  always @(negedge clk) begin
    if (rx.Rx_VALID === 1'b1) begin
      n_valid++;
      got_q.push_back(rx.Rx_DATA);
    end
    if (rx.Rx_PERROR === 1'b1) n_perr++;
    if (rx.Rx_FERROR === 1'b1) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rx.RxD = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Frame-level model: good parity and a high stop bit deliver the byte.
  task automatic frame_step(input string tag, input logic [7:0] b, input logic par,
                            input logic stp, input int hold_low);
    int v0, p0, f0, ev, ep, ef;
    logic [10:0] f;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    f = {stp, par, b, 1'b0};
    send_bits(f, 0, 10);
    if (hold_low > 0) begin
      rx.RxD = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rx.RxD = 1'b1;
    repeat (40) @(negedge clk);
    ep = (((^b) ^ par) == 1'b1) ? 1 : 0;
    ef = stp ? 0 : 1;
    ev = (ep == 0 && ef == 0) ? 1 : 0;
    if (ev == 1) exp_data = b;
    chk({tag, "_valid"}, 32'(n_valid - v0), 32'(ev));
    chk({tag, "_perr"},  32'(n_perr - p0),  32'(ep));
    chk({tag, "_ferr"},  32'(n_ferr - f0),  32'(ef));
    chk({tag, "_data"},  32'(rx.Rx_DATA),   32'(exp_data));
  endtask

  task automatic quiet_check(input string tag, input int v0, input int p0, input int f0);
    chk({tag, "_valid"}, 32'(n_valid - v0), 32'd0);
    chk({tag, "_perr"},  32'(n_perr - p0),  32'd0);
    chk({tag, "_ferr"},  32'(n_ferr - f0),  32'd0);
    chk({tag, "_data"},  32'(rx.Rx_DATA),   32'(exp_data));
  endtask

  initial begin
    int v0, p0, f0, nq;
    logic [7:0]  rb;
    logic        rp;
    logic [10:0] f;

    reset = 1'b0;
    rx.Rx_EN = 1'b0;
    rx.RxD = 1'b1;
    rx.baud_select = 3'b111;
    exp_data = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_data",  32'(rx.Rx_DATA),   32'h00);
    chk("rst_valid", 32'(rx.Rx_VALID),  32'd0);
    chk("rst_perr",  32'(rx.Rx_PERROR), 32'd0);
    chk("rst_ferr",  32'(rx.Rx_FERROR), 32'd0);
    reset = 1'b1;
    rx.Rx_EN = 1'b1;
    repeat (20) @(negedge clk);

    frame_step("good9A", 8'h9A, 1'b0, 1'b1, 0);
    frame_step("par9A",  8'h9A, 1'b1, 1'b1, 0);
    frame_step("fer55",  8'h55, 1'b0, 1'b0, 5000);

    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rx.RxD = 1'b0;
    repeat (200) @(negedge clk);
    rx.RxD = 1'b1;
    repeat (1000) @(negedge clk);
    quiet_check("glitch", v0, p0, f0);

    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_bits({1'b1, 1'b0, 8'h00, 1'b0}, 0, 10);
    send_bits({1'b1, 1'b0, 8'hFF, 1'b0}, 0, 10);
    rx.RxD = 1'b1;
    repeat (40) @(negedge clk);
    exp_data = 8'hFF;
    chk("b2b_valid", 32'(n_valid - v0), 32'd2);
    chk("b2b_perr",  32'(n_perr - p0),  32'd0);
    chk("b2b_ferr",  32'(n_ferr - f0),  32'd0);
    nq = got_q.size();
    if (nq >= 2) begin
      chk("b2b_first",  32'(got_q[nq-2]), 32'h00);
      chk("b2b_second", 32'(got_q[nq-1]), 32'hFF);
    end
    chk("b2b_data", 32'(rx.Rx_DATA), 32'(exp_data));

    // Reset asserted in the middle of data bit 4.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rb = 8'($urandom);
    f = {1'b1, ^rb, rb, 1'b0};
    send_bits(f, 0, 4);
    rx.RxD = f[5];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    rx.RxD = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (CPB) @(negedge clk);
    exp_data = 8'h00;
    quiet_check("rstabort", v0, p0, f0);

    // Full random frame with baud_select disturbed mid-frame.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rb = 8'($urandom);
    rp = (^rb) ^ ($urandom_range(0, 3) == 0);
    f = {1'b1, rp, rb, 1'b0};
    send_bits(f, 0, 3);
    rx.baud_select = 3'b000;
    send_bits(f, 4, 10);
    rx.baud_select = 3'b111;
    rx.RxD = 1'b1;
    repeat (40) @(negedge clk);
    if (((^rb) ^ rp) == 1'b0) exp_data = rb;
    chk("rand1_valid", 32'(n_valid - v0), 32'(((^rb) ^ rp) == 1'b0 ? 1 : 0));
    chk("rand1_perr",  32'(n_perr - p0),  32'(((^rb) ^ rp) == 1'b1 ? 1 : 0));
    chk("rand1_ferr",  32'(n_ferr - f0),  32'd0);
    chk("rand1_data",  32'(rx.Rx_DATA),   32'(exp_data));

    // Receiver disabled in the middle of data bit 4.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rb = 8'($urandom);
    f = {1'b1, ^rb, rb, 1'b0};
    send_bits(f, 0, 4);
    rx.RxD = f[5];
    repeat (CPB / 2) @(negedge clk);
    rx.Rx_EN = 1'b0;
    repeat (3) @(negedge clk);
    rx.RxD = 1'b1;
    repeat (3) @(negedge clk);
    rx.Rx_EN = 1'b1;
    repeat (CPB) @(negedge clk);
    quiet_check("enabort", v0, p0, f0);

    rb = 8'($urandom);
    frame_step("rand2", rb, ^rb, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
